// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, FSM states and queue entry type for instruction fetch
package fetch_pkg;

  localparam int INST_W = 32;
  localparam int ADDR_W = 32;
  localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_ctrl_if.sv
// rtl/inst_fetch_ctrl_if.sv - fetch-to-decode valid/ready handshake bundle
interface inst_fetch_ctrl_if;
  import fetch_pkg::*;

  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_pc;
  logic [INST_W-1:0] out_inst;

  modport master (output out_valid, output out_pc, output out_inst, input out_ready);
  modport slave  (input out_valid, input out_pc, input out_inst, output out_ready);

endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - small synchronous FIFO of fetched {pc, inst} entries
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wr_entry,
  output logic [CW-1:0] count,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_pop, do_push;

  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign head  = mem_q[rd_ptr_q];

  // Pointer and occupancy update; a pop frees the slot a same-cycle push needs
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; cleared on reset so the head reads zero out of reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push && !flush) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// rtl/inst_fetch_ctrl.sv - fetch PC sequencer feeding decode from a combinational ROM
module inst_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC    = 32'h0000_0000,
  parameter int                QUEUE_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [INST_W-1:0]   rom_inst,
  inst_fetch_ctrl_if.master   out_if,
  input  logic                redirect_valid,
  input  logic [ADDR_W-1:0]   redirect_pc,
  input  logic                halt,
  output logic                halted
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] redirect_aligned;
  logic              pop, fetch;
  logic [CW-1:0]     q_count;
  logic              q_full, q_empty;
  fetch_entry_t      q_head, q_wr;

  assign redirect_aligned = redirect_pc & ~32'h3;
  assign rom_addr         = pc_q;
  assign halted           = (state_q == HALTED);
  assign pop              = !q_empty && out_if.out_ready;
  assign fetch            = (state_q == RUN) && !redirect_valid && (!q_full || pop);
  assign q_wr             = '{pc: pc_q, inst: rom_inst};

  assign out_if.out_valid = !q_empty;
  assign out_if.out_pc    = q_head.pc;
  assign out_if.out_inst  = q_head.inst;

  fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clk      (clk),
    .rst      (rst),
    .push     (fetch),
    .pop      (pop),
    .flush    (redirect_valid),
    .wr_entry (q_wr),
    .count    (q_count),
    .full     (q_full),
    .empty    (q_empty),
    .head     (q_head)
  );

  // Next state and next PC; a redirect replaces the PC in every state
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      IDLE:    state_d = halt ? HALTED : RUN;
      RUN:     state_d = halt ? HALTED : RUN;
      HALTED:  state_d = halt ? HALTED : RUN;
      default: state_d = IDLE;
    endcase
    if (redirect_valid) pc_d = redirect_aligned;
    else if (fetch)     pc_d = pc_q + PC_STEP;
  end

  // State and PC registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Queue flags must agree with its occupancy
  always_ff @(posedge clk) begin
    if (!rst) assert (q_full == (q_count == CW'(QUEUE_DEPTH)));
  end

endmodule
